// File: rtl/multi_rate_clk_gen.sv
// Multi-channel programmable clock divider.
// Each channel counts 0..div_act on src_clk, toggling a 50% square wave at the
// terminal count and pulsing tick on the rising toggle. New divisors are staged
// in a per-channel shadow and only swapped in at a terminal count (or right away
// when the channel is off, or on sync_clr), so a period is never truncated.

module multi_rate_clk_gen_ch #(
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] DIV_RST = '0
) (
  input  logic             src_clk,
  input  logic             src_rst_n,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic             load_acc,
  input  logic [CNT_W-1:0] load_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] shadow;
  logic             nxt_off;

  // a staged divisor of zero turns the channel off at the swap point
  assign nxt_off = pending && (shadow == '0);

  // counter, divided output, tick and divisor swap for one channel
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      div_act <= DIV_RST;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (sync_clr) begin
        // phase restart; anything already staged takes effect now
        cnt     <= '0;
        clk_out <= 1'b0;
        if (pending) begin
          div_act <= shadow;
          pending <= 1'b0;
        end
      end else if (div_act == '0) begin
        // channel off: held quiet, staged divisor applied without waiting for enable
        cnt     <= '0;
        clk_out <= 1'b0;
        if (pending) begin
          div_act <= shadow;
          pending <= 1'b0;
        end
      end else if (enable) begin
        if (cnt == div_act) begin
          cnt <= '0;
          if (pending) begin
            div_act <= shadow;
            pending <= 1'b0;
          end
          if (nxt_off) begin
            clk_out <= 1'b0;
          end else begin
            clk_out <= ~clk_out;
            tick    <= ~clk_out;
          end
        end else if (cnt > div_act) begin
          // defensive: never let the count run past the divisor
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      // an accept in this cycle always lands in the shadow and stays staged,
      // even when the swap above consumed the previous staged value
      if (load_acc) begin
        shadow  <= load_div;
        pending <= 1'b1;
      end
    end
  end

endmodule

module multi_rate_clk_gen #(
  parameter int                        NUM_CH   = 2,
  parameter int                        CNT_W    = 24,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = {NUM_CH{24'd12500000}},
  localparam int                       CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              src_clk,
  input  logic              src_rst_n,
  input  logic              enable,
  input  logic              sync_clr,
  input  logic              load_valid,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_div,
  output logic              load_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load_acc;

  // ready follows the addressed channel; out-of-range channels always accept (and drop)
  always_comb begin
    load_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_ch == CH_W'(i)) load_ready = ~pending[i];
    end
  end

  // one-hot accept strobe per channel
  always_comb begin
    load_acc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load_acc[i] = load_valid && load_ready && (load_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_rate_clk_gen_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_ch (
      .src_clk   (src_clk),
      .src_rst_n (src_rst_n),
      .enable    (enable),
      .sync_clr  (sync_clr),
      .load_acc  (load_acc[i]),
      .load_div  (load_div),
      .pending   (pending[i]),
      .clk_out   (clk_out[i]),
      .tick      (tick[i])
    );
  end

endmodule

// File: tb/tb_multi_rate_clk_gen.sv
// Bench for multi_rate_clk_gen: directed scenarios plus a randomized run, all
// checked against a countdown-to-next-edge reference model.
module tb_multi_rate_clk_gen;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam logic [15:0] DIV_INIT = {8'd4, 8'd1};

  logic       src_clk = 1'b0;
  logic       src_rst_n;
  logic       enable, sync_clr, load_valid;
  logic [0:0] load_ch;
  logic [7:0] load_div;
  logic       load_ready;
  logic [1:0] clk_out, tick;

  int n_pass = 0, n_total = 0;

  // reference model: edges remaining until the next toggle, plus staged divisor
  int       init_div[2] = '{1, 4};
  int       m_div[2], m_shadow[2], m_rem[2];
  bit       m_pend[2];
  logic [1:0] m_clk, m_tick;
  logic     obs_ready, exp_ready;

  multi_rate_clk_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) dut (
    .src_clk(src_clk), .src_rst_n(src_rst_n), .enable(enable), .sync_clr(sync_clr),
    .load_valid(load_valid), .load_ch(load_ch), .load_div(load_div),
    .load_ready(load_ready), .clk_out(clk_out), .tick(tick)
  );

  always #5 src_clk = ~src_clk;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_div[c] = init_div[c]; m_shadow[c] = 0; m_pend[c] = 0; m_rem[c] = m_div[c] + 1;
    end
    m_clk = '0; m_tick = '0;
  endtask

  // drive one cycle of inputs, advance model over the edge, sample #1 after it
  task automatic step(input bit en, input bit clr, input bit lv, input int lch, input int ldiv);
    bit acc;
    enable = en; sync_clr = clr; load_valid = lv; load_ch = 1'(lch); load_div = 8'(ldiv);
    #1;
    obs_ready = load_ready;
    exp_ready = (lch < 2) ? !m_pend[lch] : 1'b1;
    acc = lv && exp_ready;
    @(posedge src_clk);
    for (int c = 0; c < 2; c++) begin
      if (clr) begin
        if (m_pend[c]) begin m_div[c] = m_shadow[c]; m_pend[c] = 0; end
        m_rem[c] = m_div[c] + 1; m_clk[c] = 0; m_tick[c] = 0;
      end else if (m_div[c] == 0) begin
        m_clk[c] = 0; m_tick[c] = 0;
        if (m_pend[c]) begin m_div[c] = m_shadow[c]; m_pend[c] = 0; m_rem[c] = m_div[c] + 1; end
      end else if (!en) begin
        m_tick[c] = 0;
      end else begin
        m_rem[c]--; m_tick[c] = 0;
        if (m_rem[c] == 0) begin
          if (m_pend[c]) begin m_div[c] = m_shadow[c]; m_pend[c] = 0; end
          m_rem[c] = m_div[c] + 1;
          if (m_div[c] == 0) m_clk[c] = 0;
          else begin m_tick[c] = !m_clk[c]; m_clk[c] = !m_clk[c]; end
        end
      end
      if (acc && lch == c) begin m_shadow[c] = ldiv; m_pend[c] = 1; end
    end
    #1;
  endtask

  // idle-step until clk_out[ch] changes; n = edges taken, -1 if bound expired
  task automatic run_until_toggle(input int ch, output int n);
    logic p;
    p = clk_out[ch]; n = 0;
    do begin step(1, 0, 0, 0, 0); n++; end while (clk_out[ch] === p && n < 600);
    if (clk_out[ch] === p) n = -1;
  endtask

  task automatic test_reset();
    src_rst_n = 1'b0; enable = 1; sync_clr = 0; load_valid = 0; load_ch = 0; load_div = 0;
    repeat (3) @(posedge src_clk);
    #1;
    n_total++;
    if (clk_out !== 2'b00 || tick !== 2'b00)
      $display("FAIL reset_outputs: clk_out=%b tick=%b, required 00 00", clk_out, tick);
    else n_pass++;
    load_ch = 1; #1;
    n_total++;
    if (load_ready !== 1'b1) $display("FAIL reset_ready: load_ready=%b, required 1", load_ready);
    else n_pass++;
    @(negedge src_clk); src_rst_n = 1'b1; model_reset();
  endtask

  task automatic test_free_run();
    int t0 = 0, t1 = 0, bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0, 0);
      if (clk_out !== m_clk || tick !== m_tick) bad++;
      t0 += tick[0]; t1 += tick[1];
    end
    n_total++;
    if (bad != 0) $display("FAIL free_run_model: %0d cycles differ from model, required 0", bad);
    else n_pass++;
    n_total++;
    if (t0 != 10 || t1 != 4)
      $display("FAIL free_run_ticks: ticks ch0=%0d ch1=%0d, required 10 4", t0, t1);
    else n_pass++;
  endtask

  task automatic test_load_mid();
    int n; logic p;
    run_until_toggle(0, n);
    step(1, 0, 1, 0, 3);
    n_total++;
    if (load_ready !== 1'b0) $display("FAIL load_mid_ready_low: load_ready=%b, required 0", load_ready);
    else n_pass++;
    p = clk_out[0];
    step(1, 0, 0, 0, 0);
    n_total++;
    if (clk_out[0] === p) $display("FAIL load_mid_inflight_half: clk_out[0] held at %b, required toggle", p);
    else n_pass++;
    n_total++;
    if (load_ready !== 1'b1) $display("FAIL load_mid_ready_back: load_ready=%b, required 1", load_ready);
    else n_pass++;
    run_until_toggle(0, n);
    n_total++;
    if (n != 4) $display("FAIL load_mid_new_half: half-period %0d, required 4", n);
    else n_pass++;
  endtask

  task automatic test_load_terminal();
    int n, k; logic p;
    k = 0;
    while (m_rem[1] != 1 && k < 20) begin step(1, 0, 0, 0, 0); k++; end
    p = clk_out[1];
    step(1, 0, 1, 1, 2);
    n_total++;
    if (clk_out[1] === p || load_ready !== 1'b0)
      $display("FAIL load_term_edge: clk_out[1]=%b (was %b) ready=%b, required toggle and ready 0",
               clk_out[1], p, load_ready);
    else n_pass++;
    run_until_toggle(1, n);
    n_total++;
    if (n != 5) $display("FAIL load_term_old_half: half-period %0d, required 5", n);
    else n_pass++;
    run_until_toggle(1, n);
    n_total++;
    if (n != 3) $display("FAIL load_term_new_half: half-period %0d, required 3", n);
    else n_pass++;
  endtask

  task automatic test_enable_freeze();
    int n, bad = 0; logic [1:0] s;
    run_until_toggle(0, n);
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    s = clk_out;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, 0);
      if (clk_out !== s || tick !== 2'b00 || clk_out !== m_clk) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL enable_freeze: %0d frozen cycles moved, required 0", bad);
    else n_pass++;
    run_until_toggle(0, n);
    n_total++;
    if (n != 2) $display("FAIL enable_resume_phase: %0d edges to toggle, required 2", n);
    else n_pass++;
  endtask

  task automatic test_div_zero();
    int k = 0, bad = 0;
    step(1, 0, 1, 0, 0);
    while (m_div[0] != 0 && k < 20) begin step(1, 0, 0, 0, 0); k++; end
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0);
      if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0 || clk_out !== m_clk) bad++;
    end
    n_total++;
    if (bad != 0 || k >= 20) $display("FAIL div_zero_off: %0d active cycles (k=%0d), required 0", bad, k);
    else n_pass++;
    step(1, 0, 1, 0, 2);
    step(0, 0, 0, 0, 0);   // applied even with enable low
    n_total++;
    if (load_ready !== 1'b1) $display("FAIL div_zero_apply: load_ready=%b, required 1", load_ready);
    else n_pass++;
    k = 0;
    do begin step(1, 0, 0, 0, 0); k++; end while (tick[0] !== 1'b1 && k < 20);
    n_total++;
    if (k != 3) $display("FAIL div_zero_restart: first tick after %0d clks, required 3", k);
    else n_pass++;
  endtask

  task automatic test_sync_clr();
    int n;
    step(1, 0, 1, 1, 6);
    step(1, 1, 0, 1, 0);
    n_total++;
    if (clk_out !== 2'b00 || tick !== 2'b00 || load_ready !== 1'b1)
      $display("FAIL sync_clr_state: clk_out=%b tick=%b ready=%b, required 00 00 1",
               clk_out, tick, load_ready);
    else n_pass++;
    run_until_toggle(1, n);
    n_total++;
    if (n != 7) $display("FAIL sync_clr_applied: ch1 half-period %0d, required 7", n);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int k = 0, n, bad = 0;
    while (clk_out[0] !== 1'b1 && k < 20) begin step(1, 0, 0, 0, 0); k++; end
    step(1, 0, 1, 1, 9);
    load_ch = 1;
    #2 src_rst_n = 1'b0;
    #1;
    n_total++;
    if (clk_out !== 2'b00 || tick !== 2'b00 || load_ready !== 1'b1)
      $display("FAIL async_reset: clk_out=%b tick=%b ready=%b, required 00 00 1",
               clk_out, tick, load_ready);
    else n_pass++;
    @(negedge src_clk); src_rst_n = 1'b1; model_reset();
    run_until_toggle(0, n);
    n_total++;
    if (n != 2) $display("FAIL async_reset_div_init: ch0 half-period %0d, required 2", n);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 0);
      if (clk_out !== m_clk || tick !== m_tick) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL async_reset_model: %0d cycles differ, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad_o = 0, bad_r = 0;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1), $urandom_range(0, 5));
      if (clk_out !== m_clk || tick !== m_tick) begin
        if (bad_o < 5) $display("FAIL random_outputs cyc %0d: clk_out=%b tick=%b, required %b %b",
                                i, clk_out, tick, m_clk, m_tick);
        bad_o++;
      end
      if (obs_ready !== exp_ready) bad_r++;
    end
    n_total++;
    if (bad_o != 0) $display("FAIL random_model: %0d output cycles differ, required 0", bad_o);
    else n_pass++;
    n_total++;
    if (bad_r != 0) $display("FAIL random_ready: %0d ready cycles differ, required 0", bad_r);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_mid();
    test_load_terminal();
    test_enable_freeze();
    test_div_zero();
    test_sync_clr();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
